// File: rtl/div_reservation_station_if.sv
// Bundle of dispatch, CDB and divider signals around the divider reservation station.
//   master : environment side. It drives dispatch, CDB and div_busy, and observes rs_full and
//            the registered divider issue outputs.
//   slave  : reservation station side.
// DATA_WIDTH and TAG_WIDTH must match the parameters of the attached div_reservation_station.
interface div_reservation_station_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) ();
  // Dispatch
  logic                  dispatch_valid;
  logic [DATA_WIDTH-1:0] dispatch_Vj;
  logic [DATA_WIDTH-1:0] dispatch_Vk;
  logic [TAG_WIDTH-1:0]  dispatch_Qj;
  logic [TAG_WIDTH-1:0]  dispatch_Qk;
  logic [TAG_WIDTH-1:0]  dispatch_tag;
  logic                  rs_full;
  // Common data bus
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  // Divider
  logic                  div_enable;
  logic [DATA_WIDTH-1:0] div_operand_1;
  logic [DATA_WIDTH-1:0] div_operand_2;
  logic [TAG_WIDTH-1:0]  div_tag_in;
  logic                  div_busy;

  modport master (
    output dispatch_valid, dispatch_Vj, dispatch_Vk, dispatch_Qj, dispatch_Qk, dispatch_tag,
    output cdb_valid, cdb_tag, cdb_data, div_busy,
    input  rs_full, div_enable, div_operand_1, div_operand_2, div_tag_in
  );

  modport slave (
    input  dispatch_valid, dispatch_Vj, dispatch_Vk, dispatch_Qj, dispatch_Qk, dispatch_tag,
    input  cdb_valid, cdb_tag, cdb_data, div_busy,
    output rs_full, div_enable, div_operand_1, div_operand_2, div_tag_in
  );
endinterface

// File: rtl/div_reservation_station.sv
// Reservation station for the divider functional unit.
// It accepts DIV/DIVU operations from dispatch. Missing operands are captured by snooping the
// CDB. Ready entries are issued one at a time, lowest index first, to the divider.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   flush : synchronous squash of all entries and any pending issue strobe
//   bus   : dispatch (valid/Vj/Vk/Qj/Qk/tag, rs_full), CDB (valid/tag/data) and divider
//           (enable/operand_1/operand_2/tag_in out, busy in); tag 0 means "value present"
module div_reservation_station #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input logic                      clk,
  input logic                      reset,
  input logic                      flush,
  div_reservation_station_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  data_t            vj_q[DEPTH], vj_d[DEPTH];
  data_t            vk_q[DEPTH], vk_d[DEPTH];
  tag_t             qj_q[DEPTH], qj_d[DEPTH];
  tag_t             qk_q[DEPTH], qk_d[DEPTH];
  tag_t             tag_q[DEPTH], tag_d[DEPTH];

  // Registered divider outputs
  logic  div_enable_q, div_enable_d;
  data_t div_op1_q, div_op1_d;
  data_t div_op2_q, div_op2_d;
  tag_t  div_tag_q, div_tag_d;

  logic [DEPTH-1:0] ready;
  logic [IdxW-1:0]  issue_idx, free_idx;
  logic             rs_full, issue, accept;
  logic             byp_j, byp_k;

  // Readiness is taken from registered state only, so a CDB capture becomes issuable the
  // following cycle. The loops run from high to low index so the lowest index wins.
  always_comb begin
    ready     = '0;
    issue_idx = '0;
    free_idx  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      ready[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      if (ready[i]) issue_idx = IdxW'(i);
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
  end

  assign rs_full = &valid_q;
  // !div_enable_q is required: the divider raises busy only one cycle after it samples enable.
  assign issue   = !bus.div_busy && !div_enable_q && (|ready) && !flush;
  // The slot freed by an issue is not visible to dispatch until the next cycle.
  assign accept  = bus.dispatch_valid && !rs_full;

  // Same-cycle CDB bypass into the dispatched entry
  assign byp_j = bus.cdb_valid && (bus.dispatch_Qj != '0) && (bus.dispatch_Qj == bus.cdb_tag);
  assign byp_k = bus.cdb_valid && (bus.dispatch_Qk != '0) && (bus.dispatch_Qk == bus.cdb_tag);

  always_comb begin
    valid_d      = valid_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    tag_d        = tag_q;
    div_enable_d = 1'b0;
    div_op1_d    = div_op1_q;
    div_op2_d    = div_op2_q;
    div_tag_d    = div_tag_q;

    // CDB snoop; both operands of one entry may capture from the same broadcast
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && bus.cdb_valid) begin
        if ((qj_q[i] != '0) && (qj_q[i] == bus.cdb_tag)) begin
          vj_d[i] = bus.cdb_data;
          qj_d[i] = '0;
        end
        if ((qk_q[i] != '0) && (qk_q[i] == bus.cdb_tag)) begin
          vk_d[i] = bus.cdb_data;
          qk_d[i] = '0;
        end
      end
    end

    if (issue) begin
      valid_d[issue_idx] = 1'b0;
      div_enable_d       = 1'b1;
      div_op1_d          = vj_q[issue_idx];
      div_op2_d          = vk_q[issue_idx];
      div_tag_d          = tag_q[issue_idx];
    end

    if (accept) begin
      valid_d[free_idx] = 1'b1;
      vj_d[free_idx]    = byp_j ? bus.cdb_data : bus.dispatch_Vj;
      vk_d[free_idx]    = byp_k ? bus.cdb_data : bus.dispatch_Vk;
      qj_d[free_idx]    = byp_j ? '0 : bus.dispatch_Qj;
      qk_d[free_idx]    = byp_k ? '0 : bus.dispatch_Qk;
      tag_d[free_idx]   = bus.dispatch_tag;
    end

    // Flush overrides dispatch, snoop and issue; the operand/tag outputs keep their values.
    if (flush) begin
      valid_d      = '0;
      div_enable_d = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        vj_d[i]  = '0;
        vk_d[i]  = '0;
        qj_d[i]  = '0;
        qk_d[i]  = '0;
        tag_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      div_enable_q <= 1'b0;
      div_op1_q    <= '0;
      div_op2_q    <= '0;
      div_tag_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      tag_q        <= tag_d;
      div_enable_q <= div_enable_d;
      div_op1_q    <= div_op1_d;
      div_op2_q    <= div_op2_d;
      div_tag_q    <= div_tag_d;
    end
  end

  assign bus.rs_full       = rs_full;
  assign bus.div_enable    = div_enable_q;
  assign bus.div_operand_1 = div_op1_q;
  assign bus.div_operand_2 = div_op2_q;
  assign bus.div_tag_in    = div_tag_q;

endmodule

// File: tb/tb_div_reservation_station.sv
// Directed bench for div_reservation_station. It pairs table-driven single-operation vectors
// with hand-written multi-cycle sequences: CDB capture, back-to-back issue, fill, flush and
// async reset. The divider model holds busy for six cycles after it samples enable.
module tb_div_reservation_station;
  logic clk = 1'b0;
  logic reset;
  logic flush;

  div_reservation_station_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) bus ();

  div_reservation_station #(
    .DEPTH(4),
    .DATA_WIDTH(32),
    .TAG_WIDTH(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Divider model
  int unsigned busy_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (bus.div_enable) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.div_busy = (busy_cnt != 0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_Vj    = '0;
    bus.dispatch_Vk    = '0;
    bus.dispatch_Qj    = '0;
    bus.dispatch_Qk    = '0;
    bus.dispatch_tag   = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
  endtask

  task automatic drive(input logic [31:0] vj, input logic [31:0] vk, input logic [5:0] qj,
                       input logic [5:0] qk, input logic [5:0] tag);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_Vj    = vj;
    bus.dispatch_Vk    = vk;
    bus.dispatch_Qj    = qj;
    bus.dispatch_Qk    = qk;
    bus.dispatch_tag   = tag;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.div_busy || bus.div_enable) && n < 40) begin
      step();
      n++;
    end
    if (bus.div_busy || bus.div_enable) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: divider still busy after %0d cycles", n);
    end
  endtask

  typedef struct {
    logic [31:0] vj;
    logic [31:0] vk;
    logic [5:0]  qj;
    logic [5:0]  qk;
    logic [5:0]  tag;
    logic        cdb_v;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    logic [5:0]  exp_tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int first_low;
    int en_k;
    int en_cnt;

    // vj, vk, qj, qk, tag, cdb_v, cdb_tag, cdb_data, exp_op1, exp_op2, exp_tag
    vecs[0] = '{32'd100, 32'd7, 6'd0, 6'd0, 6'd5, 1'b0, 6'd0, 32'd0, 32'd100, 32'd7, 6'd5};
    vecs[1] = '{32'd50, 32'd999, 6'd0, 6'd12, 6'd6, 1'b1, 6'd12, 32'd3, 32'd50, 32'd3, 6'd6};
    vecs[2] = '{32'd1, 32'd2, 6'd9, 6'd9, 6'd7, 1'b1, 6'd9, 32'd42, 32'd42, 32'd42, 6'd7};
    // CDB tag 0 must never bypass a Q=0 operand
    vecs[3] = '{32'd8, 32'hFFFF_FFFF, 6'd0, 6'd0, 6'd4, 1'b1, 6'd0, 32'd123,
                32'd8, 32'hFFFF_FFFF, 6'd4};
    vecs[4] = '{32'd5, 32'd0, 6'd13, 6'd0, 6'd63, 1'b1, 6'd13, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 32'd0, 6'd63};

    reset = 1'b1;
    flush = 1'b0;
    clear_inputs();
    #1;
    check("rst_full", 64'(bus.rs_full), 64'd0);
    check("rst_en", 64'(bus.div_enable), 64'd0);
    check("rst_op1", 64'(bus.div_operand_1), 64'd0);
    check("rst_op2", 64'(bus.div_operand_2), 64'd0);
    check("rst_tag", 64'(bus.div_tag_in), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Table: dispatch on edge N, issue on N+1, strobe gone after N+2
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      drive(vecs[i].vj, vecs[i].vk, vecs[i].qj, vecs[i].qk, vecs[i].tag);
      bus.cdb_valid = vecs[i].cdb_v;
      bus.cdb_tag   = vecs[i].cdb_tag;
      bus.cdb_data  = vecs[i].cdb_data;
      step();
      clear_inputs();
      check($sformatf("v%0d_en_n", i), 64'(bus.div_enable), 64'd0);
      check($sformatf("v%0d_full", i), 64'(bus.rs_full), 64'd0);
      step();
      check($sformatf("v%0d_en", i), 64'(bus.div_enable), 64'd1);
      check($sformatf("v%0d_op1", i), 64'(bus.div_operand_1), 64'(vecs[i].exp_op1));
      check($sformatf("v%0d_op2", i), 64'(bus.div_operand_2), 64'(vecs[i].exp_op2));
      check($sformatf("v%0d_tag", i), 64'(bus.div_tag_in), 64'(vecs[i].exp_tag));
      step();
      check($sformatf("v%0d_en_off", i), 64'(bus.div_enable), 64'd0);
      check($sformatf("v%0d_op1_hold", i), 64'(bus.div_operand_1), 64'(vecs[i].exp_op1));
    end

    // CDB capture two cycles after dispatch; issue one edge after capture
    wait_idle();
    drive(32'd5, 32'd11, 6'd9, 6'd0, 6'd3);
    step();
    clear_inputs();
    check("cap_en_d0", 64'(bus.div_enable), 64'd0);
    step();
    check("cap_en_d1", 64'(bus.div_enable), 64'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd9;
    bus.cdb_data  = 32'd42;
    step();
    clear_inputs();
    check("cap_en_d2", 64'(bus.div_enable), 64'd0);
    step();
    check("cap_en", 64'(bus.div_enable), 64'd1);
    check("cap_op1", 64'(bus.div_operand_1), 64'd42);
    check("cap_op2", 64'(bus.div_operand_2), 64'd11);
    check("cap_tag", 64'(bus.div_tag_in), 64'd3);

    // Back-to-back ready ops: second strobe on the first edge after busy is seen low
    wait_idle();
    drive(32'd20, 32'd4, 6'd0, 6'd0, 6'd10);
    step();
    drive(32'd30, 32'd5, 6'd0, 6'd0, 6'd11);
    step();
    clear_inputs();
    check("b2b_en1", 64'(bus.div_enable), 64'd1);
    check("b2b_tag1", 64'(bus.div_tag_in), 64'd10);
    first_low = -1;
    en_k      = -1;
    en_cnt    = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.div_enable) begin
        en_cnt++;
        if (en_k < 0) begin
          en_k = k;
          check("b2b_op1", 64'(bus.div_operand_1), 64'd30);
          check("b2b_op2", 64'(bus.div_operand_2), 64'd5);
          check("b2b_tag2", 64'(bus.div_tag_in), 64'd11);
        end
      end
      if (first_low < 0 && k > 1 && !bus.div_busy) first_low = k;
    end
    check("b2b_busy_low_k", 64'(first_low), 64'd7);
    check("b2b_en2_k", 64'(en_k), 64'd8);
    check("b2b_en_count", 64'(en_cnt), 64'd1);

    // Fill with unresolved Qj, refuse dispatch while full, then flush with a strobe pending
    wait_idle();
    for (int t = 0; t < 4; t++) begin
      drive(32'd0, 32'(t + 1), 6'd20, 6'd0, 6'(21 + t));
      step();
      if (t == 2) check("fill_full3", 64'(bus.rs_full), 64'd0);
    end
    check("fill_full4", 64'(bus.rs_full), 64'd1);
    drive(32'd1, 32'd1, 6'd0, 6'd0, 6'd25);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd20;
    bus.cdb_data  = 32'd77;
    step();
    clear_inputs();
    check("fill_full5", 64'(bus.rs_full), 64'd1);
    check("fill_en_cap", 64'(bus.div_enable), 64'd0);
    drive(32'd1, 32'd1, 6'd0, 6'd0, 6'd26);
    step();
    clear_inputs();
    check("fill_iss_en", 64'(bus.div_enable), 64'd1);
    check("fill_iss_tag", 64'(bus.div_tag_in), 64'd21);
    check("fill_iss_op1", 64'(bus.div_operand_1), 64'd77);
    check("fill_iss_op2", 64'(bus.div_operand_2), 64'd1);
    check("fill_full_drop", 64'(bus.rs_full), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_en", 64'(bus.div_enable), 64'd0);
    check("flush_full", 64'(bus.rs_full), 64'd0);
    wait_idle();
    en_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.div_enable) en_cnt++;
    end
    check("flush_no_issue", 64'(en_cnt), 64'd0);

    // Async reset while a strobe is high
    drive(32'd9, 32'd3, 6'd0, 6'd0, 6'd12);
    step();
    drive(32'd1, 32'd1, 6'd30, 6'd0, 6'd13);
    step();
    clear_inputs();
    check("ar_en", 64'(bus.div_enable), 64'd1);
    check("ar_tag", 64'(bus.div_tag_in), 64'd12);
    #2;
    reset = 1'b1;
    #1;
    check("ar_en0", 64'(bus.div_enable), 64'd0);
    check("ar_op1_0", 64'(bus.div_operand_1), 64'd0);
    check("ar_op2_0", 64'(bus.div_operand_2), 64'd0);
    check("ar_tag0", 64'(bus.div_tag_in), 64'd0);
    check("ar_full0", 64'(bus.rs_full), 64'd0);
    step();
    reset = 1'b0;
    // The unresolved entry must be gone: a broadcast of its tag must not cause an issue.
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd30;
    bus.cdb_data  = 32'd1;
    step();
    clear_inputs();
    en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.div_enable) en_cnt++;
    end
    check("ar_no_issue", 64'(en_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_reservation_station.md
# div_reservation_station

Reservation station that feeds the pipelined-latency divider functional unit in the out-of-order core. It accepts decoded DIV/DIVU operations from dispatch with operand values or producer tags, captures missing operands by snooping the common data bus (CDB), and issues ready operations to the divider one at a time. It drives the divider's enable/operand/tag inputs and honours its busy output.

## Interface

- DEPTH, 4: number of entries (2..8).
- DATA_WIDTH, 32: operand width.
- TAG_WIDTH, 6: tag width; tag value 0 means "operand value present".
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all entries and any pending issue.
- dispatch_valid  input  1  dispatch offers an operation this cycle.
- dispatch_Vj, dispatch_Vk  input  DATA_WIDTH  dividend/divisor values (meaningful when matching Q is 0).
- dispatch_Qj, dispatch_Qk  input  TAG_WIDTH  producer tags; 0 = value valid.
- dispatch_tag  input  TAG_WIDTH  destination tag of the operation (never 0).
- rs_full  output  1  all entries occupied; dispatch not accepted.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_WIDTH  broadcast producer tag.
- cdb_data  input  DATA_WIDTH  broadcast value.
- div_enable  output  1  registered one-cycle issue strobe to divider.
- div_operand_1, div_operand_2  output  DATA_WIDTH  registered dividend/divisor.
- div_tag_in  output  TAG_WIDTH  registered destination tag.
- div_busy  input  1  divider busy (low when idle).

## Operation

- Entry state: valid, Vj, Vk, Qj, Qk, tag. Reset/flush: all valid=0; Q/V/tag cleared to 0.
- Dispatch: accepted iff dispatch_valid && !rs_full; written into the lowest-index free entry on the edge.
- Dispatch bypass: if cdb_valid and cdb_tag equals a nonzero dispatch_Qj/Qk in the same cycle, the entry stores cdb_data and Q=0.
- Snoop: every cycle with cdb_valid, each valid entry with Qj (Qk) == cdb_tag (nonzero) loads cdb_data into Vj (Vk) and clears Qj (Qk). Both operands may capture from one broadcast.
- Ready: entry valid && Qj==0 && Qk==0, evaluated from registered state (capture this cycle -> ready next cycle).
- Issue condition: !div_busy && !div_enable && any ready entry && !flush. Selects lowest-index ready entry.
- On issue edge: div_enable<=1, div_operand_1<=Vj, div_operand_2<=Vk, div_tag_in<=tag; entry valid<=0 (slot reusable by dispatch the next cycle, not the same cycle).
- div_enable deasserts the following edge; operand/tag outputs hold their last values.
- The !div_enable term is mandatory: divider busy rises one cycle after it samples enable, so back-to-back issue would collide.
- rs_full = AND of all valid bits (combinational from state).
- flush: clears entries and div_enable on the edge; takes priority over dispatch, snoop and issue.

## Timing

- Reset values: rs_full=0, div_enable=0, div_operand_1=0, div_operand_2=0, div_tag_in=0.
- Reset asserted mid-operation: all entries and outputs return to reset values immediately (asynchronously).
- Dispatch with both operands ready accepted on edge N -> issued on edge N+1 -> div_enable high in cycle N+1..N+2, divider samples on edge N+2.
- Operand arriving on CDB at edge N -> earliest issue edge N+1.
- Divider captures at edge E; div_busy high for six cycles after E; next issue edge no earlier than E+6 (first cycle busy is low).
- Full with simultaneous issue: rs_full stays 1 that cycle; dispatch refused; space visible the next cycle.

## Test plan

- Reset, dispatch Vj=100, Vk=7, Q=0, tag=5 at edge 1 -> div_enable high after edge 2 only, operands 100/7, div_tag_in=5; entry freed.
- Dispatch Qj=9 (tag 3), then CDB tag=9 data=42 two cycles later -> issue one edge after capture with operand_1=42.
- Same-cycle dispatch Qk=12 with cdb_valid, cdb_tag=12, cdb_data=3 -> bypass; issued next edge with operand_2=3.
- Two ready ops dispatched back-to-back with divider model -> second div_enable exactly when busy first low after first issue; never two enables within 7 cycles.
- Fill 4 entries with unresolved Qj -> rs_full=1, fifth dispatch ignored; broadcast tag frees via issue and rs_full drops the cycle after issue.
- flush with 3 occupied entries and div_enable pending -> all invalid, div_enable=0 next cycle, rs_full=0; async reset mid-issue -> outputs 0 immediately.
